fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and sequencing stage that sits directly upstream of the instruction decoder. It drives the instruction-ROM address, and it receives the 9-bit instruction word plus the decoder's `branch` flag and the datapath's branch condition. It computes the next PC, runs the start/halt state machine that generates the decoder's `init` hold, and keeps cycle and retired-instruction counters for program-length measurement.

## Interface
- PC_W, 10, program-counter width in bits; the instruction ROM depth is 2^PC_W.
- CNT_W, 16, width of the cycle and retired-instruction counters.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled request to begin execution at address 0.
- stall  in  1  datapath not ready; holds the current instruction.
- instruction  in  9  ROM word at the current `pc`, combinational in the same cycle.
- branch  in  1  decoder flag: the current instruction is a branch (opcode 3'b111).
- condition  in  1  datapath branch condition for the current instruction.
- pc  out  PC_W  instruction-ROM address, registered.
- init  out  1  decoder hold: high in IDLE and HALT, low in RUN.
- done  out  1  high only in HALT.
- cycleCount  out  CNT_W  RUN cycles since the last start.
- retired  out  CNT_W  instructions completed since the last start.

## Operation
- The FSM has three states: IDLE, RUN and HALT. Reset enters IDLE.
- **IDLE**
  - Outputs: `init`=1, `done`=0.
  - `pc`, `cycleCount` and `retired` hold.
  - `start`=1 → RUN. On the same edge: `pc`←0, both counters ←0.
- **RUN**
  - Outputs: `init`=0, `done`=0.
  - When `stall`=1, a RUN cycle does the following:
    - `pc` holds.
    - `cycleCount`+1.
    - `retired` holds.
    - Halt detection is suppressed.
  - When `stall`=0, a RUN cycle does the following:
    - `cycleCount`+1 and `retired`+1.
    - If `branch`&&`condition`: `pc`←`pc`+sign-extend(`instruction[5:0]`), with a range of -32..+31.
    - Otherwise: `pc`←`pc`+1.
    - PC arithmetic is modulo 2^PC_W, so 0x3FF+1 wraps to 0 and 0-1 wraps to 0x3FF.
  - Halt: `instruction`==9'b111_000000 with `branch`=1 and `stall`=0 → HALT, regardless of `condition`.
    - The halt instruction counts as retired and counts as a cycle.
    - `pc` holds at the halt address; it does not advance.
  - `start` is ignored in RUN.
- **HALT**
  - Outputs: `done`=1, `init`=1.
  - `pc` and both counters are frozen.
  - `start`=1 → RUN, with the same clearing as from IDLE. `done` falls on that edge.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- `stall` is ignored outside RUN.
- A branch with `condition`=0 always falls through to `pc`+1, including a non-halt offset.
- `branch` is used exactly as delivered by the decoder. This block does not re-decode the opcode; `instruction` is used only for the offset field and halt detection.

## Timing
- Reset values:
  - state IDLE
  - `pc`=0
  - `init`=1
  - `done`=0
  - `cycleCount`=0
  - `retired`=0
- `reset` takes priority over `start`, `stall` and halt detection in the same cycle. Mid-RUN reset returns to IDLE on that edge and clears all counters.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.
- Single-cycle execution:
  - `instruction`, `branch` and `condition` are valid in the cycle `pc` is presented.
  - The next `pc` appears one edge later.
- Start latency:
  - `start` sampled high at edge N.
  - `init`=0 and `pc`=0 from N through N+1.
  - The first instruction retires at edge N+1.
- Halt latency: halt decoded in cycle K → `done`=1 after edge K.
- A one-cycle `start` pulse is sufficient. Holding `start` high has no effect after entering RUN.

## Test plan
- **Reset / idle:** assert `reset` 2 cycles, then idle 5 cycles with `start`=0 → `pc`=0, `init`=1, `done`=0, counters 0 throughout.
- **Straight-line and halt:**
  - Stimulus: pulse `start`. ROM holds ALU ops at 0..4 and 9'b111_000000 at 5 (`branch`=1).
  - Required: `pc` steps 0,1,2,3,4,5. `done`=1 one edge after `pc`=5 is presented. `retired`=6, `cycleCount`=6, `pc` stays 5.
- **Branches:**
  - At `pc`=3, `branch`=1, `condition`=1, offset 6'b111110 (−2) → next `pc`=1.
  - Same instruction with `condition`=0 → next `pc`=4.
  - At `pc`=2, offset +31 → next `pc`=33.
- **Wrap:** with PC_W=4, execute at `pc`=15 without branch → `pc`=0. At `pc`=1 with offset −2 taken → `pc`=15.
- **Stall:**
  - Stimulus: hold `stall`=1 for 3 cycles at `pc`=2, with the halt word also present.
  - Required: `pc` stays 2 and no HALT. `cycleCount` +3, `retired` unchanged. Release → HALT on the next edge.
- **Restart / reset mid-run:**
  - `start` in HALT → `pc`=0, counters 0, `done`=0 after one edge.
  - `reset` during RUN at `pc`=7 → IDLE, `pc`=0, `init`=1 on the next edge.
  - `start` during RUN → no effect.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus (master = fetch_unit side: start/stall/instruction/branch/condition in; pc/init/done/cycleCount/retired out).
interface fetch_if #(parameter int PC_W = 10, parameter int CNT_W = 16);
  logic start;
  logic stall;
  logic [8:0] instruction;
  logic branch;
  logic condition;
  logic [PC_W-1:0] pc;
  logic init;
  logic done;
  logic [CNT_W-1:0] cycleCount;
  logic [CNT_W-1:0] retired;
  modport master(input start, stall, instruction, branch, condition, output pc, init, done, cycleCount, retired);
  modport slave(output start, stall, instruction, branch, condition, input pc, init, done, cycleCount, retired);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer with IDLE/RUN/HALT control; ports clk, reset (sync, active-high) and fetch_if.master bus (pc/init/done/cycleCount/retired driven).
module fetch_unit #(
  parameter int PC_W = 10,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_next;
  logic [PC_W-1:0] pc;
  logic [CNT_W-1:0] cyc, ret;
  logic halt, go;
  assign halt = bus.branch && !bus.stall && bus.instruction == 9'b111_000000;
  assign go = state != RUN && bus.start;
  always_comb begin
    state_next = go ? RUN : (state == RUN && halt) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // Signed cast sign-extends the 6-bit offset (or truncates it for narrow PCs) to PC_W.
  always_ff @(posedge clk) begin
    if (reset || go) begin
      pc <= '0;
      cyc <= '0;
      ret <= '0;
    end else if (state == RUN) begin
      cyc <= cyc + CNT_W'(~&cyc);
      if (!bus.stall) begin
        ret <= ret + CNT_W'(~&ret);
        if (!halt) pc <= (bus.branch && bus.condition) ? pc + PC_W'($signed(bus.instruction[5:0])) : pc + PC_W'(1);
      end
    end
  end
  assign bus.pc = pc;
  assign bus.cycleCount = cyc;
  assign bus.retired = ret;
  assign bus.init = state != RUN;
  assign bus.done = state == HALT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (PC_W=10 main instance, PC_W=4/CNT_W=4 wrap instance).
module tb_fetch_unit;
  localparam logic [8:0] ALU = 9'b000_000_001;
  localparam logic [8:0] HALTW = 9'b111_000000;
  logic clk = 1'b0;
  logic reset, reset_w;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fetch_if #(.PC_W(10), .CNT_W(16)) b ();
  fetch_if #(.PC_W(4), .CNT_W(4)) w ();
  fetch_unit #(.PC_W(10), .CNT_W(16)) u (.clk(clk), .reset(reset), .bus(b));
  fetch_unit #(.PC_W(4), .CNT_W(4)) uw (.clk(clk), .reset(reset_w), .bus(w));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [8:0] ins, input logic br, input logic cnd);
    b.instruction = ins;
    b.branch = br;
    b.condition = cnd;
    tick();
  endtask

  task automatic pulse_start;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; reset_w = 1'b1;
    b.start = 0; b.stall = 0; b.instruction = ALU; b.branch = 0; b.condition = 0;
    w.start = 0; w.stall = 0; w.instruction = ALU; w.branch = 0; w.condition = 0;
    repeat (2) tick();
    reset = 1'b0; reset_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b.pc !== 10'd0 || b.init !== 1'b1 || b.done !== 1'b0 || b.cycleCount !== 16'd0 || b.retired !== 16'd0) begin
        failures++;
        $display("FAIL idle[%0d] pc=%0d init=%b done=%b cyc=%0d ret=%0d exp 0 1 0 0 0", i, b.pc, b.init, b.done, b.cycleCount, b.retired);
      end
    end
  endtask

  task automatic test_straight_halt;
    pulse_start();
    checks++;
    if (b.pc !== 10'd0 || b.init !== 1'b0) begin
      failures++;
      $display("FAIL start pc=%0d init=%b exp 0 0", b.pc, b.init);
    end
    for (int i = 0; i < 5; i++) begin
      exec(ALU, 0, 0);
      checks++;
      if (b.pc !== 10'(i + 1)) begin
        failures++;
        $display("FAIL step pc=%0d exp %0d", b.pc, i + 1);
      end
    end
    exec(HALTW, 1, 1);
    checks++;
    if (b.done !== 1'b1 || b.init !== 1'b1 || b.pc !== 10'd5 || b.retired !== 16'd6 || b.cycleCount !== 16'd6) begin
      failures++;
      $display("FAIL halt done=%b init=%b pc=%0d ret=%0d cyc=%0d exp 1 1 5 6 6", b.done, b.init, b.pc, b.retired, b.cycleCount);
    end
    exec(ALU, 0, 0);
    checks++;
    if (b.done !== 1'b1 || b.pc !== 10'd5 || b.retired !== 16'd6 || b.cycleCount !== 16'd6) begin
      failures++;
      $display("FAIL frozen done=%b pc=%0d ret=%0d cyc=%0d exp 1 5 6 6", b.done, b.pc, b.retired, b.cycleCount);
    end
  endtask

  task automatic test_branch_restart;
    pulse_start();
    checks++;
    if (b.pc !== 10'd0 || b.done !== 1'b0 || b.retired !== 16'd0 || b.cycleCount !== 16'd0) begin
      failures++;
      $display("FAIL restart pc=%0d done=%b ret=%0d cyc=%0d exp 0 0 0 0", b.pc, b.done, b.retired, b.cycleCount);
    end
    repeat (3) exec(ALU, 0, 0);
    exec(9'b111_111110, 1, 0);
    checks++;
    if (b.pc !== 10'd4) begin failures++; $display("FAIL br_not_taken pc=%0d exp 4", b.pc); end
    exec(9'b111_111111, 1, 1);
    checks++;
    if (b.pc !== 10'd3) begin failures++; $display("FAIL br_m1 pc=%0d exp 3", b.pc); end
    exec(9'b111_111110, 1, 1);
    checks++;
    if (b.pc !== 10'd1) begin failures++; $display("FAIL br_m2 pc=%0d exp 1", b.pc); end
    exec(ALU, 0, 0);
    exec(9'b111_011111, 1, 1);
    checks++;
    if (b.pc !== 10'd33) begin failures++; $display("FAIL br_p31 pc=%0d exp 33", b.pc); end
    b.start = 1'b1;
    exec(ALU, 0, 0);
    b.start = 1'b0;
    checks++;
    if (b.pc !== 10'd34 || b.init !== 1'b0) begin
      failures++;
      $display("FAIL start_in_run pc=%0d init=%b exp 34 0", b.pc, b.init);
    end
    exec(9'b111_100101, 1, 1);
    checks++;
    if (b.pc !== 10'd7 || b.retired !== 16'd10 || b.cycleCount !== 16'd10) begin
      failures++;
      $display("FAIL br_m27 pc=%0d ret=%0d cyc=%0d exp 7 10 10", b.pc, b.retired, b.cycleCount);
    end
    reset = 1'b1;
    b.start = 1'b1;
    exec(HALTW, 1, 1);
    reset = 1'b0;
    b.start = 1'b0;
    checks++;
    if (b.pc !== 10'd0 || b.init !== 1'b1 || b.done !== 1'b0 || b.retired !== 16'd0 || b.cycleCount !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_run pc=%0d init=%b done=%b ret=%0d cyc=%0d exp 0 1 0 0 0", b.pc, b.init, b.done, b.retired, b.cycleCount);
    end
  endtask

  task automatic test_stall;
    pulse_start();
    repeat (2) exec(ALU, 0, 0);
    b.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exec(HALTW, 1, 0);
      checks++;
      if (b.pc !== 10'd2 || b.done !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d] pc=%0d done=%b exp 2 0", i, b.pc, b.done);
      end
    end
    checks++;
    if (b.cycleCount !== 16'd5 || b.retired !== 16'd2) begin
      failures++;
      $display("FAIL stall_counts cyc=%0d ret=%0d exp 5 2", b.cycleCount, b.retired);
    end
    b.stall = 1'b0;
    exec(HALTW, 1, 0);
    checks++;
    if (b.done !== 1'b1 || b.pc !== 10'd2 || b.retired !== 16'd3 || b.cycleCount !== 16'd6) begin
      failures++;
      $display("FAIL stall_release done=%b pc=%0d ret=%0d cyc=%0d exp 1 2 3 6", b.done, b.pc, b.retired, b.cycleCount);
    end
    b.stall = 1'b1;
    exec(ALU, 0, 0);
    b.stall = 1'b0;
    checks++;
    if (b.done !== 1'b1 || b.pc !== 10'd2 || b.cycleCount !== 16'd6) begin
      failures++;
      $display("FAIL stall_in_halt done=%b pc=%0d cyc=%0d exp 1 2 6", b.done, b.pc, b.cycleCount);
    end
  endtask

  task automatic test_wrap_saturate;
    w.start = 1'b1;
    tick();
    w.start = 1'b0;
    repeat (15) tick();
    checks++;
    if (w.pc !== 4'd15 || w.cycleCount !== 4'd15) begin
      failures++;
      $display("FAIL wrap_pre pc=%0d cyc=%0d exp 15 15", w.pc, w.cycleCount);
    end
    tick();
    checks++;
    if (w.pc !== 4'd0 || w.cycleCount !== 4'd15 || w.retired !== 4'd15) begin
      failures++;
      $display("FAIL wrap_sat pc=%0d cyc=%0d ret=%0d exp 0 15 15", w.pc, w.cycleCount, w.retired);
    end
    tick();
    w.instruction = 9'b111_111110;
    w.branch = 1'b1;
    w.condition = 1'b1;
    tick();
    checks++;
    if (w.pc !== 4'd15) begin failures++; $display("FAIL wrap_neg pc=%0d exp 15", w.pc); end
  endtask

  initial begin
    test_reset();
    test_straight_halt();
    test_branch_restart();
    test_stall();
    test_wrap_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
